// File: rtl/conv_pool_engine_if.sv
// Bus bundle for conv_pool_engine: frame handshake, image ROM port, layer memory port and weight load port.
interface conv_pool_engine_if #(
  parameter int AW = 12,
  parameter int DW = 20
);
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;
  logic          w_we;
  logic [4:0]    w_addr;
  logic [DW-1:0] w_data;

  modport master (
    input  ready, idata, cdata_rd, w_we, w_addr, w_data,
    output busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
  modport slave (
    output ready, idata, cdata_rd, w_we, w_addr, w_data,
    input  busy, iaddr, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/conv_pool_engine.sv
// 3x3 convolution + ReLU (layer 0) then 2x2/stride-2 max-pool (layer 1) for one or two kernels per frame.
// Define CONV_PERF_EN to add the cycle_cnt port counting the busy cycles of the most recent frame.
module conv_pool_engine #(
  parameter int IMG_W_LOG2  = 6,
  parameter int DATA_W      = 20,
  parameter int FRAC_W      = 16,
  parameter int NUM_KERNELS = 1
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef CONV_PERF_EN
  output logic [31:0]        cycle_cnt,
`endif
  conv_pool_engine_if.master bus
);
  localparam int LW    = IMG_W_LOG2;
  localparam int AW    = 2 * LW;
  localparam int W     = 1 << LW;
  localparam int ACC_W = 2 * DATA_W + 4;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1) << (FRAC_W - 1);

  typedef enum logic [2:0] {IDLE, L0_RD, L0_WR, L1_RD, L1_WR, DONE} state_t;

  state_t                    state;
  logic                      kern;
  logic [LW-1:0]             row, col, nrow, ncol;
  logic [LW-2:0]             prow, pcol, nprow, npcol;
  logic [3:0]                tap, nxt_tap, first_nxt;
  logic [1:0]                quad;
  logic signed [ACC_W-1:0]   acc, acc_sum, rounded;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]         conv_out, pool_max, max_next;
  logic [2:0]                l0_code, l1_code;
  logic signed [DATA_W-1:0]  wts [2][10];
  logic                      w_hit, w_k;
  logic [3:0]                w_i;

  function automatic logic tap_ok(input logic [LW-1:0] r, input logic [LW-1:0] c, input int t);
    int rr, cc;
    rr = int'(r) + t / 3 - 1;
    cc = int'(c) + t % 3 - 1;
    return (rr >= 0) && (rr < W) && (cc >= 0) && (cc < W);
  endfunction

  // Lowest in-image tap at or after 'from'; 9 means the pixel has no taps left.
  function automatic logic [3:0] first_tap(input logic [LW-1:0] r, input logic [LW-1:0] c,
                                           input logic [3:0] from);
    logic [3:0] t;
    t = 4'd9;
    for (int i = 8; i >= 0; i--)
      if (i >= int'(from) && tap_ok(r, c, i)) t = 4'(i);
    return t;
  endfunction

  function automatic logic [AW-1:0] tap_addr(input logic [LW-1:0] r, input logic [LW-1:0] c,
                                             input logic [3:0] t);
    logic [LW-1:0] rr, cc;
    rr = r + LW'(t / 4'd3) - 1'b1;
    cc = c + LW'(t % 4'd3) - 1'b1;
    return {rr, cc};
  endfunction

  function automatic logic [AW-1:0] l1_addr(input logic [LW-2:0] pr, input logic [LW-2:0] pc,
                                            input logic [1:0] q);
    return {pr, q[1], pc, q[0]};
  endfunction

  function automatic logic signed [ACC_W-1:0] scale_bias(input logic signed [DATA_W-1:0] b);
    return ACC_W'(b) <<< FRAC_W;
  endfunction

  always_comb begin
    prod    = $signed(bus.idata) * wts[kern][tap];
    acc_sum = acc + ACC_W'(prod);
    rounded = (acc_sum + ROUND) >>> FRAC_W;
    if (rounded < 0)          conv_out = '0;
    else if (rounded > MAX_V) conv_out = MAX_V[DATA_W-1:0];
    else                      conv_out = rounded[DATA_W-1:0];
    nxt_tap        = first_tap(row, col, tap + 4'd1);
    {nrow, ncol}   = {row, col} + 1'b1;
    first_nxt      = first_tap(nrow, ncol, 4'd0);
    {nprow, npcol} = {prow, pcol} + 1'b1;
    max_next = (quad == 2'd0 || bus.cdata_rd > pool_max) ? bus.cdata_rd : pool_max;
    l0_code  = kern ? 3'b010 : 3'b001;
    l1_code  = kern ? 3'b100 : 3'b011;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      kern         <= 1'b0;
      row          <= '0;
      col          <= '0;
      prow         <= '0;
      pcol         <= '0;
      tap          <= '0;
      quad         <= '0;
      acc          <= '0;
      pool_max     <= '0;
      bus.busy     <= 1'b0;
      bus.crd      <= 1'b0;
      bus.cwr      <= 1'b0;
      bus.csel     <= 3'b000;
      bus.iaddr    <= '0;
      bus.caddr_rd <= '0;
      bus.caddr_wr <= '0;
      bus.cdata_wr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ready) begin
            state     <= L0_RD;
            bus.busy  <= 1'b1;
            bus.csel  <= 3'b001;
            kern      <= 1'b0;
            row       <= '0;
            col       <= '0;
            tap       <= 4'd4;
            bus.iaddr <= '0;
            acc       <= scale_bias(wts[0][9]);
          end
        end
        L0_RD: begin
          acc <= acc_sum;
          if (nxt_tap != 4'd9) begin
            tap       <= nxt_tap;
            bus.iaddr <= tap_addr(row, col, nxt_tap);
          end else begin
            state        <= L0_WR;
            bus.cwr      <= 1'b1;
            bus.caddr_wr <= {row, col};
            bus.cdata_wr <= conv_out;
          end
        end
        L0_WR: begin
          bus.cwr <= 1'b0;
          if ({row, col} == '1) begin
            state        <= L1_RD;
            row          <= '0;
            col          <= '0;
            prow         <= '0;
            pcol         <= '0;
            quad         <= '0;
            bus.crd      <= 1'b1;
            bus.caddr_rd <= '0;
          end else begin
            state     <= L0_RD;
            row       <= nrow;
            col       <= ncol;
            tap       <= first_nxt;
            bus.iaddr <= tap_addr(nrow, ncol, first_nxt);
            acc       <= scale_bias(wts[kern][9]);
          end
        end
        L1_RD: begin
          pool_max <= max_next;
          if (quad != 2'd3) begin
            quad         <= quad + 2'd1;
            bus.caddr_rd <= l1_addr(prow, pcol, quad + 2'd1);
          end else begin
            state        <= L1_WR;
            bus.crd      <= 1'b0;
            bus.cwr      <= 1'b1;
            bus.csel     <= l1_code;
            bus.caddr_wr <= AW'({prow, pcol});
            bus.cdata_wr <= max_next;
          end
        end
        L1_WR: begin
          bus.cwr <= 1'b0;
          if ({prow, pcol} == '1) begin
            prow <= '0;
            pcol <= '0;
            // Second kernel restarts layer 0 directly from pixel 0 without leaving busy.
            if (NUM_KERNELS == 2 && !kern) begin
              state     <= L0_RD;
              kern      <= 1'b1;
              bus.csel  <= 3'b010;
              tap       <= 4'd4;
              bus.iaddr <= '0;
              acc       <= scale_bias(wts[1][9]);
            end else begin
              state    <= DONE;
              kern     <= 1'b0;
              bus.busy <= 1'b0;
              bus.csel <= 3'b000;
            end
          end else begin
            state        <= L1_RD;
            prow         <= nprow;
            pcol         <= npcol;
            quad         <= '0;
            bus.crd      <= 1'b1;
            bus.csel     <= l0_code;
            bus.caddr_rd <= l1_addr(nprow, npcol, 2'd0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_k   = (bus.w_addr >= 5'd10);
    w_i   = w_k ? 4'(bus.w_addr - 5'd10) : bus.w_addr[3:0];
    w_hit = bus.w_we && !bus.busy && (bus.w_addr < 5'(10 * NUM_KERNELS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 10; i++)
          wts[k][i] <= '0;
    end else if (w_hit) begin
      wts[w_k][w_i] <= bus.w_data;
    end
  end

`ifdef CONV_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      cycle_cnt <= '0;
    else if (state == IDLE && bus.ready) cycle_cnt <= '0;
    else if (bus.busy)                 cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_conv_pool_engine.sv
// Scoreboard bench for conv_pool_engine on an 8x8 image with two kernels; a queue of expected
// layer-memory writes is filled from a plain-arithmetic model and drained by an independent monitor.
module tb_conv_pool_engine;
  localparam int LW = 3;
  localparam int AW = 2 * LW;
  localparam int W  = 1 << LW;
  localparam int N  = W * W;
  localparam int P  = (W / 2) * (W / 2);
  localparam int DW = 20;
  localparam int FW = 16;
  localparam int NK = 2;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint HALF = longint'(1) << (FW - 1);

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  int   busy_cycles = 0;
  wr_t  exp_q[$];
  logic [DW-1:0] img [N];
  logic [DW-1:0] lmem [2][N];
  logic [DW-1:0] wt [NK][10];
`ifdef CONV_PERF_EN
  logic [31:0] cycle_cnt;
`endif

  conv_pool_engine_if #(.AW(AW), .DW(DW)) bus ();

  conv_pool_engine #(
    .IMG_W_LOG2(LW), .DATA_W(DW), .FRAC_W(FW), .NUM_KERNELS(NK)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef CONV_PERF_EN
    .cycle_cnt(cycle_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Image ROM and layer memory answer combinationally; writes land on the clock edge.
  assign bus.idata    = img[bus.iaddr];
  assign bus.cdata_rd = lmem[bus.csel == 3'b010][bus.caddr_rd];
  always @(posedge clk)
    if (bus.cwr === 1'b1 && (bus.csel == 3'b001 || bus.csel == 3'b010))
      lmem[bus.csel == 3'b010][bus.caddr_wr] <= bus.cdata_wr;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [DW-1:0] rnd(input int mag);
    int v;
    v = int'($urandom_range(0, (2 << mag) - 1)) - (1 << mag);
    return DW'(v);
  endfunction

  // Reference: direct 3x3 sum with zero padding, round, saturate, ReLU, then 2x2 max.
  task automatic push_expected(output int cycles);
    longint l0v [N];
    longint s, m;
    int r, c, rr, cc;
    wr_t e;
    cycles = 0;
    for (int k = 0; k < NK; k++) begin
      for (int p = 0; p < N; p++) begin
        r = p / W;
        c = p % W;
        s = sx(wt[k][9]) * (longint'(1) << FW);
        for (int t = 0; t < 9; t++) begin
          rr = r + t / 3 - 1;
          cc = c + t % 3 - 1;
          if (rr >= 0 && rr < W && cc >= 0 && cc < W) begin
            s += sx(img[rr * W + cc]) * sx(wt[k][t]);
            cycles++;
          end
        end
        cycles++;
        s = (s + HALF) >>> FW;
        if (s > MAXV) s = MAXV;
        if (s < 0) s = 0;
        l0v[p] = s;
        e.sel = (k == 0) ? 3'd1 : 3'd2;
        e.addr = AW'(p);
        e.data = DW'(s);
        exp_q.push_back(e);
      end
      for (int q = 0; q < P; q++) begin
        r = q / (W / 2);
        c = q % (W / 2);
        m = 0;
        for (int d = 0; d < 4; d++)
          if (l0v[(2 * r + d / 2) * W + 2 * c + d % 2] > m) m = l0v[(2 * r + d / 2) * W + 2 * c + d % 2];
        e.sel = (k == 0) ? 3'd3 : 3'd4;
        e.addr = AW'(q);
        e.data = DW'(m);
        exp_q.push_back(e);
        cycles += 5;
      end
    end
  endtask

  task automatic write_weights();
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.w_we = 1'b1;
        bus.w_addr = 5'(k * 10 + i);
        bus.w_data = wt[k][i];
      end
    @(negedge clk);
    bus.w_addr = 5'd31;
    bus.w_data = rnd(19);
    @(negedge clk);
    bus.w_we = 1'b0;
  endtask

  task automatic apply_stimulus(output int cycles);
    push_expected(cycles);
    busy_cycles = 0;
    @(negedge clk);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit poke);
    int exp_cycles;
    int i;
    apply_stimulus(exp_cycles);
    check_output({tag, ":busy_rise"}, 64'(bus.busy), 64'd1);
    i = 0;
    while (bus.busy === 1'b1 && i < 20000) begin
      @(negedge clk);
      if (poke && i == 40) begin
        bus.w_we = 1'b1;
        bus.w_addr = 5'd4;
        bus.w_data = rnd(19);
      end else begin
        bus.w_we = 1'b0;
      end
      i++;
    end
    bus.w_we = 1'b0;
    check_output({tag, ":frame_end"}, 64'(bus.busy), 64'd0);
    check_output({tag, ":writes_left"}, 64'(exp_q.size()), 64'd0);
    check_output({tag, ":busy_cycles"}, 64'(busy_cycles), 64'(exp_cycles));
`ifdef CONV_PERF_EN
    check_output({tag, ":cycle_cnt"}, 64'(cycle_cnt), 64'(exp_cycles));
`endif
  endtask

  task automatic reset_mid_frame();
    int cyc;
    bit seen;
    seen = 1'b0;
    apply_stimulus(cyc);
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (bus.cwr === 1'b1 && bus.csel == 3'b001 && bus.caddr_wr == AW'(20)) seen = 1'b1;
    end
    check_output("rst:pixel20_seen", 64'(seen), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check_output("rst:busy", 64'(bus.busy), 64'd0);
    check_output("rst:cwr", 64'(bus.cwr), 64'd0);
    check_output("rst:crd", 64'(bus.crd), 64'd0);
    check_output("rst:csel", 64'(bus.csel), 64'd0);
    exp_q.delete();
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 10; i++) wt[k][i] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic fill_random(input int mag);
    for (int p = 0; p < N; p++) img[p] = rnd(mag);
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 10; i++) wt[k][i] = rnd(mag);
  endtask

  // Monitor: every layer-memory write must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.crd === 1'b1 || bus.cwr === 1'b1)
        check_output("strobe_overlap", 64'(bus.crd & bus.cwr), 64'd0);
      if (bus.crd === 1'b1)
        check_output("rd_csel", 64'(bus.csel == 3'b001 || bus.csel == 3'b010), 64'd1);
      if (bus.cwr === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: csel=%0d addr=%0d data=0x%0h, expected no write",
                   bus.csel, bus.caddr_wr, bus.cdata_wr);
        end else begin
          e = exp_q.pop_front();
          check_output("wr_csel", 64'(bus.csel), 64'(e.sel));
          check_output("wr_addr", 64'(bus.caddr_wr), 64'(e.addr));
          check_output("wr_data", 64'(bus.cdata_wr), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.ready = 1'b0;
    bus.w_we = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    reset_n = 1'b0;
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < 10; i++) wt[k][i] = '0;
    repeat (3) @(negedge clk);
    check_output("reset:busy", 64'(bus.busy), 64'd0);
    check_output("reset:crd", 64'(bus.crd), 64'd0);
    check_output("reset:cwr", 64'(bus.cwr), 64'd0);
    check_output("reset:csel", 64'(bus.csel), 64'd0);
    check_output("reset:iaddr", 64'(bus.iaddr), 64'd0);
    check_output("reset:caddr_rd", 64'(bus.caddr_rd), 64'd0);
    check_output("reset:caddr_wr", 64'(bus.caddr_wr), 64'd0);
    check_output("reset:cdata_wr", 64'(bus.cdata_wr), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] identity K0 / negated identity K1 on ramp");
    for (int p = 0; p < N; p++) img[p] = DW'(p);
    wt[0][4] = 20'h10000;
    wt[1][4] = 20'hF0000;
    write_weights();
    run_frame("ident", 1'b0);

    $display("[TB] saturation");
    for (int p = 0; p < N; p++) img[p] = 20'h10000;
    for (int i = 0; i < 9; i++) wt[0][i] = 20'h10000;
    wt[0][9] = '0;
    write_weights();
    run_frame("sat", 1'b0);

    $display("[TB] rounding and negative bias");
    for (int p = 0; p < N; p++) img[p] = 20'h00001;
    for (int i = 0; i < 10; i++) wt[0][i] = '0;
    wt[0][4] = 20'h08000;
    write_weights();
    run_frame("round", 1'b0);
    for (int p = 0; p < N; p++) img[p] = '0;
    wt[0][4] = '0;
    wt[0][9] = 20'hF0000;
    write_weights();
    run_frame("negbias", 1'b0);

    $display("[TB] random frames");
    fill_random(16);
    write_weights();
    run_frame("rand_poke", 1'b1);
    fill_random(19);
    write_weights();
    run_frame("rand_full", 1'b0);

    $display("[TB] reset mid-frame");
    fill_random(16);
    write_weights();
    reset_mid_frame();
    run_frame("cleared_wts", 1'b0);
    fill_random(16);
    write_weights();
    run_frame("reload", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
